microcode_sequencer: RTL and testbench

Parametrised control sequencer for the 8-bit CPU. It drives the 16-bit control word to the datapath, one microinstruction per clock. It is a step counter plus microcode lookup with variable-length instructions: early step reset on each opcode's last step, flag-conditional jumps (JC/JZ) and a sticky HALT state. It sits between the instruction register and flags register on one side and every datapath enable on the other.

---
 rtl/sap_ctrl_pkg.sv | 44 ++++
 rtl/microcode_rom.sv | 90 +++++++++
 rtl/microcode_sequencer.sv | 99 +++++++++
 tb/tb_microcode_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP control path: control-word bit masks, opcodes,
// sequencer states and the two fetch microwords common to every instruction.
package sap_ctrl_pkg;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [15:0] FETCH_S0 = C_MI | C_CO;
    localparam logic [15:0] FETCH_S1 = C_RO | C_II | C_CE;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> (microword, last step).
// Unlisted opcodes and out-of-range upper opcode bits decode as NOP.
module microcode_rom
    import sap_ctrl_pkg::*;
#(
    parameter int STEP_W   = 3,
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [STEP_W-1:0]   i_step,
    input  logic                i_carry,
    input  logic                i_zero,
    output logic [15:0]         o_word,
    output logic                o_last
);

    logic [3:0] w_op;

    if (OPCODE_W > 4) begin : g_wide_op
        assign w_op = (|i_opcode[OPCODE_W-1:4]) ? OP_NOP : i_opcode[3:0];
    end else begin : g_narrow_op
        assign w_op = 4'(i_opcode);
    end

    logic w_s2;
    logic w_s3;

    assign w_s2 = (i_step == STEP_W'(2));
    assign w_s3 = (i_step == STEP_W'(3));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_word = '0;
        o_last = 1'b0;
        if (i_step == '0) begin
            o_word = FETCH_S0;
        end else if (i_step == STEP_W'(1)) begin
            o_word = FETCH_S1;
        end else begin
            case (w_op)
                OP_LDA: begin
                    o_word = w_s2 ? (C_IO | C_MI) : (C_RO | C_AI);
                    o_last = !w_s2;
                end
                OP_ADD, OP_SUB: begin
                    if (w_s2) begin
                        o_word = C_IO | C_MI;
                    end else if (w_s3) begin
                        o_word = C_RO | C_BI;
                    end else begin
                        o_word = C_EO | C_AI | C_FI | ((w_op == OP_SUB) ? C_SU : 16'h0000);
                        o_last = 1'b1;
                    end
                end
                OP_STA: begin
                    o_word = w_s2 ? (C_IO | C_MI) : (C_AO | C_RI);
                    o_last = !w_s2;
                end
                OP_LDI: begin
                    o_word = C_IO | C_AI;
                    o_last = 1'b1;
                end
                OP_JMP: begin
                    o_word = C_IO | C_J;
                    o_last = 1'b1;
                end
                OP_JC: begin
                    o_word = i_carry ? (C_IO | C_J) : 16'h0000;
                    o_last = 1'b1;
                end
                OP_JZ: begin
                    o_word = i_zero ? (C_IO | C_J) : 16'h0000;
                    o_last = 1'b1;
                end
                OP_OUT: begin
                    o_word = C_AO | C_OI;
                    o_last = 1'b1;
                end
                OP_HLT: begin
                    o_word = C_HLT;
                    o_last = 1'b1;
                end
                default: begin
                    o_last = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Step counter + registered control word with RUN/sticky-HALT states.
// Optional instruction counter enabled by MICROCODE_INSTR_COUNT_EN.
module microcode_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter  int STEPS    = 5,
    parameter  int OPCODE_W = 4,
    parameter  int CTRL_W   = 16,
    localparam int STEP_W   = $clog2(STEPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [CTRL_W-1:0]   ctrl_data,
    output logic [STEP_W-1:0]   step,
    output logic                halted
`ifdef MICROCODE_INSTR_COUNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    state_e            r_state;
    logic [STEP_W-1:0] r_step;
    logic [CTRL_W-1:0] r_ctrl;

    state_e            w_state_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [15:0]       w_word;
    logic              w_rom_last;
    logic              w_last;

    microcode_rom #(
        .STEP_W   (STEP_W),
        .OPCODE_W (OPCODE_W)
    ) u_rom (
        .i_opcode (instruction),
        .i_step   (r_step),
        .i_carry  (carry_flag),
        .i_zero   (zero_flag),
        .o_word   (w_word),
        .o_last   (w_rom_last)
    );

    // The final step slot always ends the instruction, truncating long sequences.
    assign w_last = w_rom_last || (r_step == STEP_W'(STEPS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_ctrl_nxt  = r_ctrl;
        case (r_state)
            ST_RUN: begin
                w_ctrl_nxt = CTRL_W'(w_word);
                w_step_nxt = w_last ? '0 : r_step + STEP_W'(1);
                if ((w_word & C_HLT) != 16'h0000) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_step  <= '0;
            r_ctrl  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    assign ctrl_data = r_ctrl;
    assign step      = r_step;
    assign halted    = (r_state == ST_HALT);

`ifdef MICROCODE_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (r_state == ST_RUN && r_step == '0) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: sequence-table model compared every cycle, plus literal checks.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  instruction;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl_data;
    logic [2:0]  step;
    logic        halted;
`ifdef MICROCODE_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    microcode_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .ctrl_data   (ctrl_data),
        .step        (step),
        .halted      (halted)
`ifdef MICROCODE_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each opcode is a list of microwords; a position walks that list.
    function automatic int seq_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [15:0] seq_word(input logic [3:0] op, input int idx,
                                             input logic c, input logic z);
        logic [15:0] t [3];
        t = '{16'h0000, 16'h0000, 16'h0000};
        case (op)
            4'h1: t = '{16'h4800, 16'h1200, 16'h0000};
            4'h2: t = '{16'h4800, 16'h1020, 16'h0281};
            4'h3: t = '{16'h4800, 16'h1020, 16'h02C1};
            4'h4: t = '{16'h4800, 16'h2100, 16'h0000};
            4'h5: t[0] = 16'h0A00;
            4'h6: t[0] = 16'h0802;
            4'h7: t[0] = c ? 16'h0802 : 16'h0000;
            4'h8: t[0] = z ? 16'h0802 : 16'h0000;
            4'hE: t[0] = 16'h0110;
            4'hF: t[0] = 16'h8000;
            default: ;
        endcase
        if (idx == 0) return 16'h4004;
        if (idx == 1) return 16'h1408;
        return t[idx-2];
    endfunction

    logic [15:0] m_ctrl  = '0;
    int          m_pos   = 0;
    logic        m_halt  = 1'b0;
    logic [31:0] m_count = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl  <= '0;
            m_pos   <= 0;
            m_halt  <= 1'b0;
            m_count <= '0;
        end else if (!m_halt) begin
            m_ctrl <= seq_word(instruction, m_pos, carry_flag, zero_flag);
            if (m_pos == 0) m_count <= m_count + 32'd1;
            if (m_pos >= seq_len(instruction) - 1) begin
                m_pos <= 0;
                if (instruction == 4'hF) m_halt <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_ctrl", 32'(ctrl_data), 32'(m_ctrl));
            check("mdl_step", 32'(step), 32'(m_pos));
            check("mdl_halt", 32'(halted), 32'(m_halt));
`ifdef MICROCODE_INSTR_COUNT_EN
            check("mdl_count", instr_count, m_count);
`endif
        end
    end

    task automatic edge_expect(input string name, input logic [15:0] w);
        @(negedge clk);
        check(name, 32'(ctrl_data), 32'(w));
    endtask

    task automatic run_to_fetch();
        for (int i = 0; i < 8; i++) begin
            if (step == 3'd0) break;
            @(negedge clk);
        end
        check("fetch_bound", 32'(step), 32'd0);
    endtask

    typedef struct { logic [3:0] op; logic z; } vec_t;
    vec_t vecs [9];

    initial begin
        rst = 1'b1;
        instruction = 4'h0;
        carry_flag = 1'b0;
        zero_flag = 1'b0;
        vecs = '{'{4'h1, 1'b0}, '{4'h3, 1'b0}, '{4'h4, 1'b0}, '{4'h6, 1'b0},
                 '{4'h8, 1'b1}, '{4'h8, 1'b0}, '{4'hE, 1'b0}, '{4'hA, 1'b0},
                 '{4'h0, 1'b0}};
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'(ctrl_data), 32'h0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        rst = 1'b0;

        instruction = 4'h5;
        edge_expect("ldi_s0", 16'h4004);
        check("ldi_step1", 32'(step), 32'd1);
        edge_expect("ldi_s1", 16'h1408);
        edge_expect("ldi_s2", 16'h0A00);
        check("ldi_step0", 32'(step), 32'd0);
        edge_expect("ldi_next", 16'h4004);
        check("ldi_next_step", 32'(step), 32'd1);
        run_to_fetch();

        instruction = 4'h2;
        edge_expect("add_s0", 16'h4004);
        edge_expect("add_s1", 16'h1408);
        edge_expect("add_s2", 16'h4800);
        carry_flag = 1'b1;
        edge_expect("add_s3", 16'h1020);
        carry_flag = 1'b0;
        edge_expect("add_s4", 16'h0281);
        edge_expect("add_e6", 16'h4004);
        run_to_fetch();

        instruction = 4'h7;
        carry_flag = 1'b1;
        edge_expect("jc1_s0", 16'h4004);
        edge_expect("jc1_s1", 16'h1408);
        edge_expect("jc1_s2", 16'h0802);
        check("jc1_len", 32'(step), 32'd0);
        carry_flag = 1'b0;
        edge_expect("jc0_s0", 16'h4004);
        edge_expect("jc0_s1", 16'h1408);
        edge_expect("jc0_s2", 16'h0000);
        check("jc0_len", 32'(step), 32'd0);
        carry_flag = 1'b1;
        edge_expect("jc0_after", 16'h4004);
        run_to_fetch();

        foreach (vecs[k]) begin
            instruction = vecs[k].op;
            zero_flag = vecs[k].z;
            @(negedge clk);
            run_to_fetch();
        end
        instruction = 4'hA;
        edge_expect("op1010_s0", 16'h4004);
        edge_expect("op1010_s1", 16'h1408);
        edge_expect("op1010_s2", 16'h0000);

        instruction = 4'hF;
        edge_expect("hlt_s0", 16'h4004);
        edge_expect("hlt_s1", 16'h1408);
        edge_expect("hlt_s2", 16'h8000);
        check("hlt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            instruction = 4'(i);
            carry_flag = i[0];
            zero_flag = i[1];
            edge_expect("hlt_hold", 16'h8000);
            check("hlt_hold_step", 32'(step), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("hlt_rst_ctrl", 32'(ctrl_data), 32'h0);
        check("hlt_rst_halt", 32'(halted), 32'd0);
        #1 rst = 1'b0;

        instruction = 4'h1;
        edge_expect("lda_s0", 16'h4004);
        edge_expect("lda_s1", 16'h1408);
        edge_expect("lda_s2", 16'h4800);
        edge_expect("lda_s3", 16'h1200);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 32'(ctrl_data), 32'h0);
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_halt", 32'(halted), 32'd0);
        #1 rst = 1'b0;
        edge_expect("post_rst", 16'h4004);
        run_to_fetch();
        instruction = 4'h5;
        repeat (3) begin
            @(negedge clk);
            run_to_fetch();
        end
`ifdef MICROCODE_INSTR_COUNT_EN
        check("count_4", instr_count, 32'd4);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
